// File: rtl/vga_sync_if.sv
// Video timing bundle driven by vga_sync: position, sync, blanking and strobes.
interface vga_sync_if;
    logic [9:0] o_pixel_x;
    logic [9:0] o_pixel_y;
    logic       o_visible_area;
    logic       o_hsync;
    logic       o_vsync;
    logic       o_pixel_en;
    logic       o_frame_tick;

    modport master (
        output o_pixel_x, o_pixel_y, o_visible_area, o_hsync, o_vsync, o_pixel_en, o_frame_tick
    );
    modport slave (
        input  o_pixel_x, o_pixel_y, o_visible_area, o_hsync, o_vsync, o_pixel_en, o_frame_tick
    );
endinterface

// File: rtl/vga_sync.sv
// VGA timing generator: raster position counters with registered syncs and strobes.
// Define VGA_SYNC_CLKDIV2_EN to hold each pixel position for two i_clk cycles.
module vga_sync #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       i_clk,
    input  logic       i_reset,
    vga_sync_if.master vga
);
    localparam logic [9:0] HLast      = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] VLast      = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] HVis       = 10'(H_VISIBLE);
    localparam logic [9:0] VVis       = 10'(V_VISIBLE);
    localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_q, y_q, x_d, y_d;
    logic       hsync_q, vsync_q, vis_q, tick_q, pen_q;
    logic       adv;

`ifdef VGA_SYNC_CLKDIV2_EN
    logic phase_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= ~phase_q;
        end
    end

    assign adv = phase_q;
`else
    // Reset is the only thing holding the raster still in the undivided build.
    assign adv = 1'b1;
`endif

    // Any count at or beyond the last position wraps, so stray values self-heal.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (x_q >= HLast) begin
            x_d = 10'd0;
            y_d = (y_q >= VLast) ? 10'd0 : y_q + 10'd1;
        end else begin
            x_d = x_q + 10'd1;
            if (y_q > VLast) begin
                y_d = 10'd0;
            end
        end
    end

    // Outputs are decoded from the next position so they stay coherent with x/y.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            x_q     <= HLast;
            y_q     <= VLast;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            vis_q   <= 1'b0;
            tick_q  <= 1'b0;
            pen_q   <= 1'b0;
        end else begin
            pen_q  <= adv;
            tick_q <= 1'b0;
            if (adv) begin
                x_q     <= x_d;
                y_q     <= y_d;
                hsync_q <= !((x_d >= HSyncStart) && (x_d < HSyncEnd));
                vsync_q <= !((y_d >= VSyncStart) && (y_d < VSyncEnd));
                vis_q   <= (x_d < HVis) && (y_d < VVis);
                tick_q  <= (x_d == 10'd0) && (y_d == VVis);
            end
        end
    end

    assign vga.o_pixel_x      = x_q;
    assign vga.o_pixel_y      = y_q;
    assign vga.o_hsync        = hsync_q;
    assign vga.o_vsync        = vsync_q;
    assign vga.o_visible_area = vis_q;
    assign vga.o_frame_tick   = tick_q;
    assign vga.o_pixel_en     = pen_q;
endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a default-size and a shrunken instance against a raster model,
// with randomized asynchronous resets.
module tb_vga_sync;
`ifdef VGA_SYNC_CLKDIV2_EN
    localparam int Div = 2;
`else
    localparam int Div = 1;
`endif
    // Shrunken timing: 15 pixels x 13 lines = 195 positions per frame.
    localparam int SHv = 8, SHf = 2, SHs = 3, SHb = 2;
    localparam int SVv = 6, SVf = 2, SVs = 2, SVb = 3;
    localparam int SFrame = (SHv + SHf + SHs + SHb) * (SVv + SVf + SVs + SVb);

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit vis;
        bit tick;
        bit pen;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    int   c = 0;

    always #5 clk = ~clk;

    vga_sync_if full_if ();
    vga_sync_if small_if ();

    vga_sync u_full (
        .i_clk   (clk),
        .i_reset (rst),
        .vga     (full_if)
    );

    vga_sync #(
        .H_VISIBLE (SHv), .H_FRONT (SHf), .H_SYNC (SHs), .H_BACK (SHb),
        .V_VISIBLE (SVv), .V_FRONT (SVf), .V_SYNC (SVs), .V_BACK (SVb)
    ) u_small (
        .i_clk   (clk),
        .i_reset (rst),
        .vga     (small_if)
    );

    // Raster position as a linear pixel index of the n-th advance since reset.
    function automatic exp_t model(int hv, int hf, int hsw, int hb, int vv, int vf, int vsw,
                                   int vb, int cyc);
        exp_t e;
        int ht = hv + hf + hsw + hb;
        int vt = vv + vf + vsw + vb;
        int nadv = cyc / Div;
        int idx;
        e.pen = (cyc > 0) && (cyc % Div == 0);
        if (nadv == 0) begin
            e.x = ht - 1;
            e.y = vt - 1;
        end else begin
            idx = (nadv - 1) % (ht * vt);
            e.x = idx % ht;
            e.y = idx / ht;
        end
        e.hs   = !(e.x >= hv + hf && e.x < hv + hf + hsw);
        e.vs   = !(e.y >= vv + vf && e.y < vv + vf + vsw);
        e.vis  = (e.x < hv) && (e.y < vv);
        e.tick = e.pen && (e.x == 0) && (e.y == vv);
        return e;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_dut(string tag, logic [9:0] x, logic [9:0] y, logic hs, logic vs,
                             logic vis, logic tick, logic pen, exp_t e);
        check({tag, ".x"}, 32'(x), e.x);
        check({tag, ".y"}, 32'(y), e.y);
        check({tag, ".hsync"}, 32'(hs), 32'(e.hs));
        check({tag, ".vsync"}, 32'(vs), 32'(e.vs));
        check({tag, ".visible"}, 32'(vis), 32'(e.vis));
        check({tag, ".tick"}, 32'(tick), 32'(e.tick));
        check({tag, ".pen"}, 32'(pen), 32'(e.pen));
    endtask

    task automatic check_all(string tag, int cyc);
        check_dut({tag, ".full"}, full_if.o_pixel_x, full_if.o_pixel_y, full_if.o_hsync,
                  full_if.o_vsync, full_if.o_visible_area, full_if.o_frame_tick,
                  full_if.o_pixel_en, model(640, 16, 96, 48, 480, 10, 2, 33, cyc));
        check_dut({tag, ".small"}, small_if.o_pixel_x, small_if.o_pixel_y, small_if.o_hsync,
                  small_if.o_vsync, small_if.o_visible_area, small_if.o_frame_tick,
                  small_if.o_pixel_en, model(SHv, SHf, SHs, SHb, SVv, SVf, SVs, SVb, cyc));
    endtask

    task automatic step();
        @(posedge clk);
        c++;
        @(negedge clk);
        check_all("run", c);
    endtask

    int hs_low = 0, hs_first = -1, hs_back = -1;
    int vis_cnt = 0, vs_low = 0, ticks = 0, tick_x = -1, tick_y = -1;

    initial begin
        repeat (3) @(negedge clk);
        check_all("reset", 0);
        rst = 1'b0;
        c = 0;
        for (int i = 0; i < 1600 * Div + 20; i++) begin
            step();
            if (full_if.o_pixel_y == 10'd0) begin
                if (!full_if.o_hsync) begin
                    if (hs_low == 0) hs_first = int'(full_if.o_pixel_x);
                    hs_low++;
                end else if (hs_low > 0 && hs_back < 0) begin
                    hs_back = int'(full_if.o_pixel_x);
                end
            end
            if (c <= SFrame * Div) begin
                vis_cnt += int'(small_if.o_visible_area);
                vs_low  += int'(!small_if.o_vsync);
                if (small_if.o_frame_tick) begin
                    ticks++;
                    tick_x = int'(small_if.o_pixel_x);
                    tick_y = int'(small_if.o_pixel_y);
                end
            end
        end
        check("line0.hsync_low_cycles", hs_low, 96 * Div);
        check("line0.hsync_first_low_x", hs_first, 656);
        check("line0.hsync_high_again_x", hs_back, 752);
        check("frame.visible_cycles", vis_cnt, SHv * SVv * Div);
        check("frame.vsync_low_cycles", vs_low, SVs * (SHv + SHf + SHs + SHb) * Div);
        check("frame.tick_count", ticks, 1);
        check("frame.tick_x", tick_x, 0);
        check("frame.tick_y", tick_y, SVv);

        // Random run lengths, then reset asserted between clock edges.
        for (int t = 0; t < 25; t++) begin
            repeat ($urandom_range(1, 3 * SFrame * Div)) step();
            #($urandom_range(1, 4));
            rst = 1'b1;
            #1;
            check_all("async_reset", 0);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            check_all("held_reset", 0);
            rst = 1'b0;
            c = 0;
        end
        repeat (SFrame * Div + 5) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
